barrett_reduce_pipe: RTL and testbench

- Parametrised, pipelined Barrett modular reducer for any compile-time modulus Q.
- Per transaction it computes either x mod Q for a 2K-bit operand, or (a*b) mod Q for two K-bit residues.
- Valid/ready handshake on both sides with full backpressure; fixed 4-cycle latency.
- Sits between NTT/polynomial butterfly datapaths and coefficient buffers, replacing the fixed-modulus combinational reducers.

---
 rtl/barrett_pkg.sv | 16 +
 rtl/barrett_csub2.sv | 22 ++
 rtl/barrett_reduce_pipe.sv | 86 ++++++++
 tb/tb_barrett_reduce_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reducers.
package barrett_pkg;

    localparam logic MODE_RED = 1'b0;  // reduce a 2K-bit operand
    localparam logic MODE_MUL = 1'b1;  // reduce the product of two residues
    localparam int   STAGES   = 4;

    function automatic int barrett_clog2(input int v);
        return $clog2(v);
    endfunction

    function automatic longint barrett_mu(input longint q, input int k);
        return (longint'(1) << (2 * k)) / q;
    endfunction

endpackage

// File: rtl/barrett_csub2.sv
// Double conditional subtract: folds a value in [0, 3Q) down to [0, Q).
module barrett_csub2
    import barrett_pkg::*;
#(
    parameter int Q = 3259,
    parameter int K = 12
) (
    input  logic [K+1:0] r_in,
    output logic [K-1:0] r_out
);

    localparam int          RW = K + 2;
    localparam logic [RW-1:0] QW = RW'(Q);

    logic [RW-1:0] t1;

    always_comb begin
        t1    = (r_in >= QW) ? r_in - QW : r_in;
        r_out = (t1 >= QW) ? K'(t1 - QW) : t1[K-1:0];
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Four-stage Barrett reducer: x mod Q or (a*b) mod Q with a global-stall handshake.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter  int Q     = 3259,
    parameter  int TAG_W = 4,
    localparam int K     = barrett_clog2(Q)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [2*K-1:0]     din_a,
    input  logic [K-1:0]       din_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [K-1:0]       dout_r,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int XW = 2 * K;
    localparam int PW = 2 * K + 2;
    localparam int RW = K + 2;
    localparam int MW = K + 1;
    localparam logic [MW-1:0] MU = MW'(barrett_mu(Q, K));

    if (Q < 3 || (Q & (Q - 1)) == 0) begin : g_bad_q
        $error("barrett_reduce_pipe: Q must be >= 3 and not a power of two");
    end

    logic [STAGES:1]    vld_pipe;
    logic               advance;
    logic [XW-1:0]      prod;
    logic [XW-1:0]      x1, x2;
    logic [PW-1:0]      q2;
    logic [RW-1:0]      r3;
    logic [K-1:0]       r4_next;
    logic [TAG_W-1:0]   tag1, tag2, tag3;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign prod      = XW'(din_a[K-1:0]) * XW'(din_b);

    barrett_csub2 #(.Q(Q), .K(K)) u_csub2 (
        .r_in  (r3),
        .r_out (r4_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            x1       <= '0;
            x2       <= '0;
            q2       <= '0;
            r3       <= '0;
            tag1     <= '0;
            tag2     <= '0;
            tag3     <= '0;
            dout_r   <= '0;
            out_tag  <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            // S1: select operand
            x1       <= (in_mode == MODE_RED) ? din_a : prod;
            tag1     <= in_tag;
            // S2: quotient estimate, full width
            q2       <= PW'(x1 >> (K - 1)) * PW'(MU);
            x2       <= x1;
            tag2     <= tag1;
            // S3: remainder is < 3Q, so K+2 bits of the difference are exact
            r3       <= RW'(x2) - RW'((q2 >> (K + 1)) * PW'(Q));
            tag3     <= tag2;
            // S4: final correction
            dout_r   <= r4_next;
            out_tag  <= tag3;
        end
    end

    a_mul_operands: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready && in_mode == MODE_MUL) |->
            (din_a[K-1:0] < K'(Q) && din_b < K'(Q)));

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Randomized self-checking bench for barrett_reduce_pipe against a plain x mod Q model.
module tb_barrett_reduce_pipe;
    import barrett_pkg::*;

    localparam int Q = 3259, K = 12, TW = 4;
    localparam int Q7 = 7681, K7 = 13, Q12 = 12289, K12 = 14;
    localparam int N_ALT = 10000;

    typedef struct { int r; int tag; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [2*K-1:0] din_a;
    logic [K-1:0]   din_b, dout_r;
    logic [TW-1:0]  in_tag, out_tag;

    logic b_iv, b_ir, b_mode, b_ov, c_iv, c_ir, c_mode, c_ov, alt_ordy;
    logic [2*K7-1:0]  b_da;
    logic [K7-1:0]    b_db, b_dr;
    logic [2*K12-1:0] c_da;
    logic [K12-1:0]   c_db, c_dr;
    logic [TW-1:0]    b_tag, b_otag, c_tag, c_otag;

    int errors = 0, checks = 0;
    exp_t sb[$];

    barrett_reduce_pipe #(.Q(Q), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .din_a(din_a), .din_b(din_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .dout_r(dout_r), .out_tag(out_tag));

    barrett_reduce_pipe #(.Q(Q7), .TAG_W(TW)) dut7 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_mode),
        .din_a(b_da), .din_b(b_db), .in_tag(b_tag), .out_valid(b_ov),
        .out_ready(alt_ordy), .dout_r(b_dr), .out_tag(b_otag));

    barrett_reduce_pipe #(.Q(Q12), .TAG_W(TW)) dut12 (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_mode(c_mode),
        .din_a(c_da), .din_b(c_db), .in_tag(c_tag), .out_valid(c_ov),
        .out_ready(alt_ordy), .dout_r(c_dr), .out_tag(c_otag));

    function automatic int golden(input logic m, input longint a, input longint b,
                                  input int k, input int q);
        longint x;
        x = m ? (a % (longint'(1) << k)) * b : a;
        return int'(x % q);
    endfunction

    // One cycle on the main DUT; records the expected result of any accepted item.
    task automatic drive(input logic v, input logic m, input longint a, input longint b,
                         input int t, input logic ordy);
        @(negedge clk);
        in_valid = v; in_mode = m; din_a = a[2*K-1:0]; din_b = b[K-1:0];
        in_tag = t[TW-1:0]; out_ready = ordy;
        #1;
        if (v && in_ready) sb.push_back('{golden(m, a, b, K, Q), t});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, MODE_RED, 5, 0, 9, 1'b1);
        drive(1'b1, MODE_RED, 6, 0, 9, 1'b0);
        drive(1'b0, MODE_RED, 0, 0, 0, 1'b0);
        rst = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (dout_r !== '0)      begin errors++; $display("FAIL reset_dout_r: got %0d want 0", dout_r); end
        if (out_tag !== '0)     begin errors++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        sb.delete();
    endtask

    task automatic test_single();
        drive(1'b1, MODE_RED, 10000000, 0, 3, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, MODE_RED, 0, 0, 0, 1'b1);
            if (i < 4) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early cycle %0d: got valid %b want 0", i, out_valid); end
            end
        end
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (dout_r !== 12'd1388) begin errors++; $display("FAIL single_r: got %0d want 1388", dout_r); end
        if (out_tag !== 4'd3)    begin errors++; $display("FAIL single_tag: got %0d want 3", out_tag); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        longint ins[3];
        int     want[3];
        ins  = '{16777215, 0, 3259};
        want = '{3142, 0, 0};
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1'b1, MODE_RED, ins[c], 0, c + 1, 1'b1);
            else       drive(1'b0, MODE_RED, 0, 0, 0, 1'b1);
            checks++;
            if (out_valid !== (c >= 4 && c <= 6)) begin
                errors++; $display("FAIL b2b_valid cycle %0d: got %b", c, out_valid);
            end else if (out_valid) begin
                checks++;
                if (int'(dout_r) !== want[c-4] || int'(out_tag) !== c - 3) begin
                    errors++; $display("FAIL b2b_data cycle %0d: got r=%0d tag=%0d want r=%0d tag=%0d",
                                       c, dout_r, out_tag, want[c-4], c - 3);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_mul();
        longint a[2], b[2];
        int     want[2], tg[2];
        a    = '{(longint'($urandom_range(1, 4095)) << 12) | 3258, 1234};
        b    = '{3258, 2000};
        want = '{1, 937};
        tg   = '{5, 9};
        for (int c = 0; c < 7; c++) begin
            if (c < 2) drive(1'b1, MODE_MUL, a[c], b[c], tg[c], 1'b1);
            else       drive(1'b0, MODE_RED, 0, 0, 0, 1'b1);
            checks++;
            if (out_valid !== (c == 4 || c == 5)) begin
                errors++; $display("FAIL mul_valid cycle %0d: got %b", c, out_valid);
            end else if (out_valid) begin
                checks++;
                if (int'(dout_r) !== want[c-4] || int'(out_tag) !== tg[c-4]) begin
                    errors++; $display("FAIL mul_data cycle %0d: got r=%0d tag=%0d want r=%0d tag=%0d",
                                       c, dout_r, out_tag, want[c-4], tg[c-4]);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_stream_stall();
        int sent, t, c;
        logic v, m, ordy, prev_stall;
        longint a, b;
        logic [K-1:0] prev_r;
        logic [TW-1:0] prev_t;
        exp_t e;
        sent = 0; prev_stall = 1'b0; prev_r = '0; prev_t = '0;
        for (c = 0; c < 300 && (sent < 20 || sb.size() > 0); c++) begin
            v    = (sent < 20) && ($urandom_range(0, 3) != 0);
            ordy = !(c >= 10 && c < 15);
            m    = 1'($urandom_range(0, 1));
            a    = m ? ((longint'($urandom_range(0, 4095)) << 12) | longint'($urandom_range(0, Q - 1)))
                     : longint'($urandom_range(0, (1 << 24) - 1));
            b    = longint'($urandom_range(0, Q - 1));
            t    = int'($urandom_range(0, 15));
            drive(v, m, a, b, t, ordy);
            if (v && in_ready) sent++;
            checks++;
            if (in_ready !== (!out_valid || ordy)) begin
                errors++; $display("FAIL stream_in_ready cycle %0d: got %b out_valid=%b out_ready=%b", c, in_ready, out_valid, ordy);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || dout_r !== prev_r || out_tag !== prev_t) begin
                    errors++; $display("FAIL stream_hold cycle %0d: got v=%b r=%0d tag=%0d want v=1 r=%0d tag=%0d",
                                       c, out_valid, dout_r, out_tag, prev_r, prev_t);
                end
            end
            if (out_valid && ordy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stream_extra cycle %0d: got r=%0d with nothing expected", c, dout_r);
                end else begin
                    e = sb.pop_front();
                    if (int'(dout_r) !== e.r || int'(out_tag) !== e.tag) begin
                        errors++; $display("FAIL stream_data cycle %0d: got r=%0d tag=%0d want r=%0d tag=%0d",
                                           c, dout_r, out_tag, e.r, e.tag);
                    end
                end
            end
            prev_stall = out_valid && !ordy;
            prev_r = dout_r; prev_t = out_tag;
        end
        checks++;
        if (sent != 20 || sb.size() != 0) begin
            errors++; $display("FAIL stream_drain: sent %0d of 20, %0d results missing", sent, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) drive(1'b1, MODE_RED, longint'($urandom_range(0, (1 << 24) - 1)), 0, 12, 1'b1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        sb.delete();
        drive(1'b1, MODE_RED, Q - 1, 0, 7, 1'b1);
        for (int c = 1; c < 8; c++) begin
            drive(1'b0, MODE_RED, 0, 0, 0, 1'b1);
            checks++;
            if (out_valid !== (c == 4)) begin
                errors++; $display("FAIL rst_mid_stray cycle %0d: got valid %b", c, out_valid);
            end else if (out_valid) begin
                checks++;
                if (int'(dout_r) !== Q - 1 || out_tag !== 4'd7) begin
                    errors++; $display("FAIL rst_mid_data: got r=%0d tag=%0d want r=%0d tag=7", dout_r, out_tag, Q - 1);
                end
            end
        end
        sb.delete();
    endtask

    task automatic test_alt_moduli();
        exp_t q7[$], q12[$];
        exp_t e;
        logic m;
        longint a, b;
        int t;
        for (int c = 0; c < N_ALT + 8; c++) begin
            @(negedge clk);
            if (b_ov) begin
                checks++;
                if (q7.size() == 0) begin
                    errors++; $display("FAIL alt7_extra cycle %0d: got r=%0d", c, b_dr);
                end else begin
                    e = q7.pop_front();
                    if (int'(b_dr) !== e.r || int'(b_otag) !== e.tag || b_dr >= K7'(Q7)) begin
                        errors++; $display("FAIL alt7_data cycle %0d: got r=%0d tag=%0d want r=%0d tag=%0d",
                                           c, b_dr, b_otag, e.r, e.tag);
                    end
                end
            end
            if (c_ov) begin
                checks++;
                if (q12.size() == 0) begin
                    errors++; $display("FAIL alt12_extra cycle %0d: got r=%0d", c, c_dr);
                end else begin
                    e = q12.pop_front();
                    if (int'(c_dr) !== e.r || int'(c_otag) !== e.tag || c_dr >= K12'(Q12)) begin
                        errors++; $display("FAIL alt12_data cycle %0d: got r=%0d tag=%0d want r=%0d tag=%0d",
                                           c, c_dr, c_otag, e.r, e.tag);
                    end
                end
            end
            b_iv = (c < N_ALT);
            c_iv = (c < N_ALT);
            if (c < N_ALT) begin
                m = 1'($urandom_range(0, 1));
                a = m ? ((longint'($urandom) << K7) | longint'($urandom_range(0, Q7 - 1)))
                      : (longint'($urandom) % (longint'(1) << (2 * K7)));
                b = longint'($urandom_range(0, Q7 - 1));
                t = int'($urandom_range(0, 15));
                b_mode = m; b_da = a[2*K7-1:0]; b_db = b[K7-1:0]; b_tag = t[TW-1:0];
                q7.push_back('{golden(m, a, b, K7, Q7), t});
                m = 1'($urandom_range(0, 1));
                a = m ? ((longint'($urandom) << K12) | longint'($urandom_range(0, Q12 - 1)))
                      : (longint'($urandom) % (longint'(1) << (2 * K12)));
                b = longint'($urandom_range(0, Q12 - 1));
                t = int'($urandom_range(0, 15));
                c_mode = m; c_da = a[2*K12-1:0]; c_db = b[K12-1:0]; c_tag = t[TW-1:0];
                q12.push_back('{golden(m, a, b, K12, Q12), t});
            end
        end
        checks++;
        if (q7.size() != 0 || q12.size() != 0) begin
            errors++; $display("FAIL alt_drain: got %0d/%0d results missing want 0/0", q7.size(), q12.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; din_a = '0; din_b = '0; in_tag = '0; out_ready = 1'b1;
        b_iv = 1'b0; b_mode = 1'b0; b_da = '0; b_db = '0; b_tag = '0;
        c_iv = 1'b0; c_mode = 1'b0; c_da = '0; c_db = '0; c_tag = '0;
        alt_ordy = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_stream_stall();
        test_reset_midflight();
        test_alt_moduli();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
